// File: rtl/axi_lite_reg_bank_if.sv
// axi_lite_reg_bank_if: user-side request/response bundle between the AXI-Lite slave and the register bank
interface axi_lite_reg_bank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_reg_in_rdy;
  logic [ADDR_WIDTH-1:0] i_reg_address;
  logic [DATA_WIDTH-1:0] i_reg_in_data;
  logic                  o_reg_in_ack_stb;
  logic                  i_reg_out_req;
  logic                  o_reg_out_rdy_stb;
  logic [DATA_WIDTH-1:0] o_reg_out_data;
  logic                  o_reg_invalid_addr;
  logic                  o_irq;
  modport master (
    output i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    input  o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_irq
  );
  modport slave (
    input  i_reg_in_rdy, i_reg_address, i_reg_in_data, i_reg_out_req,
    output o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_out_data, o_reg_invalid_addr, o_irq
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// axi_lite_reg_bank: control/status/scratch/counter/compare/W1C-irq registers behind the AXI-Lite slave user port
module axi_lite_reg_bank #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          RESP_DELAY = 0,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input logic clk,
  input logic rst,
  axi_lite_reg_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, RESPOND, RELEASE} state_t;
  state_t                state, state_nxt;
  logic [7:0]            cnt;
  logic                  op_wr, valid, wr, clr, ack_nxt, rdy_nxt, en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata, scratch, counter, compare, rdata;
  logic [1:0]            irq_en, irq_sts, irq_set, w1c;

  assign valid   = addr[1:0] == 2'b00 && addr <= ADDR_WIDTH'(5'h18);
  assign wr      = state == RESPOND && op_wr && valid;
  assign clr     = wr && addr[4:0] == 5'h00 && wdata[1];
  assign w1c     = wr && addr[4:0] == 5'h14 ? wdata[1:0] : 2'b00;
  // a clear in the same edge suppresses both the increment and its match/wrap events
  assign irq_set = en && !clr ? {counter == '1, counter + DATA_WIDTH'(1) == compare} : 2'b00;

  always_comb begin
    rdata = '0;
    case (addr[4:0])
      5'h00:   rdata = DATA_WIDTH'({irq_en, 7'b0, en});
      5'h04:   rdata = DATA_WIDTH'({bus.o_irq, en});
      5'h08:   rdata = scratch;
      5'h0C:   rdata = counter;
      5'h10:   rdata = compare;
      5'h14:   rdata = DATA_WIDTH'(irq_sts);
      5'h18:   rdata = DATA_WIDTH'(VERSION);
      default: rdata = '0;
    endcase
    if (!valid) rdata = '0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_reg_in_rdy || bus.i_reg_out_req) state_nxt = RESP_DELAY == 0 ? RESPOND : DELAY;
      DELAY:   if (cnt == 8'd1) state_nxt = RESPOND;
      RESPOND: state_nxt = RELEASE;
      RELEASE: if (!(op_wr ? bus.i_reg_in_rdy : bus.i_reg_out_req)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt = state == RESPOND && op_wr;
    rdy_nxt = state == RESPOND && !op_wr;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.o_reg_in_ack_stb   <= 1'b0;
      bus.o_reg_out_rdy_stb  <= 1'b0;
      bus.o_reg_out_data     <= '0;
      bus.o_reg_invalid_addr <= 1'b0;
      bus.o_irq              <= 1'b0;
      cnt                    <= '0;
      op_wr                  <= 1'b0;
      addr                   <= '0;
      wdata                  <= '0;
      en                     <= 1'b0;
      irq_en                 <= '0;
      irq_sts                <= '0;
      scratch                <= '0;
      counter                <= '0;
      compare                <= '0;
    end else begin
      bus.o_reg_in_ack_stb  <= ack_nxt;
      bus.o_reg_out_rdy_stb <= rdy_nxt;
      bus.o_irq             <= |(irq_sts & irq_en);
      irq_sts               <= (irq_sts & ~w1c) | irq_set;
      counter               <= clr ? '0 : en ? counter + DATA_WIDTH'(1) : counter;
      cnt                   <= state == IDLE ? 8'(RESP_DELAY) : state == DELAY ? cnt - 8'd1 : cnt;
      if (state == IDLE) begin
        op_wr <= bus.i_reg_in_rdy;
        addr  <= bus.i_reg_address;
        wdata <= bus.i_reg_in_data;
      end
      if (state == RESPOND) begin
        bus.o_reg_invalid_addr <= !valid;
        if (!op_wr) bus.o_reg_out_data <= rdata;
      end
      if (wr && addr[4:0] == 5'h00) begin
        en     <= wdata[0];
        irq_en <= wdata[9:8];
      end
      if (wr && addr[4:0] == 5'h08) scratch <= wdata;
      if (wr && addr[4:0] == 5'h10) compare <= wdata;
    end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb_axi_lite_reg_bank: randomized scoreboard bench for a 32-bit zero-delay bank and a 16-bit three-cycle-delay bank
module tb_axi_lite_reg_bank;
  typedef struct { bit w; logic [31:0] d; bit inv; longint e; } exp_t;
  logic        clk = 0, rst = 1;
  bit          sel = 0;
  logic        rdy = 0, req = 0;
  logic [31:0] addr = 0, wdat = 0;
  logic        ack, rstb, inv, irq;
  logic [31:0] rdat;
  longint      cyc = 0;
  int          checks = 0, errors = 0;
  exp_t        q[$];
  bit          m_en;
  logic [1:0]  m_ien, m_sts;
  longint      m_scr, m_cmp, m_cbase, m_cw, M;
  int          D;
  logic [31:0] ver;

  axi_lite_reg_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  axi_lite_reg_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) b1 ();
  axi_lite_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_DELAY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  axi_lite_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .RESP_DELAY(3), .VERSION(32'h0002_5A3C)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  assign b0.i_reg_in_rdy  = rdy && !sel;
  assign b1.i_reg_in_rdy  = rdy && sel;
  assign b0.i_reg_out_req = req && !sel;
  assign b1.i_reg_out_req = req && sel;
  assign b0.i_reg_address = addr;
  assign b1.i_reg_address = addr;
  assign b0.i_reg_in_data = wdat;
  assign b1.i_reg_in_data = wdat[15:0];
  assign ack  = sel ? b1.o_reg_in_ack_stb : b0.o_reg_in_ack_stb;
  assign rstb = sel ? b1.o_reg_out_rdy_stb : b0.o_reg_out_rdy_stb;
  assign inv  = sel ? b1.o_reg_invalid_addr : b0.o_reg_invalid_addr;
  assign irq  = sel ? b1.o_irq : b0.o_irq;
  assign rdat = sel ? {16'h0, b1.o_reg_out_data} : b0.o_reg_out_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d, bank %0d)", nm, act, exp, cyc, sel);
    end
  endtask

  // Counter is modelled as a straight line in time since the last transaction edge m_cw.
  function automatic longint cnt_pre(longint e);
    return m_en ? (m_cbase + e - 1 - m_cw) % M : m_cbase;
  endfunction

  function automatic bit hit(longint t, longint hi);
    longint d;
    d = ((t - m_cbase - 1) % M + M) % M;
    return m_en && m_cw + 1 + d <= hi;
  endfunction

  function automatic logic [1:0] sts_post(longint e);
    return m_sts | {hit(0, e), hit(m_cmp, e)};
  endfunction

  task automatic model_reset();
    m_en = 0; m_ien = 0; m_sts = 0; m_scr = 0; m_cmp = 0; m_cbase = 0; m_cw = cyc;
  endtask

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d, input longint r,
                       output logic [31:0] v, output bit iv);
    longint pre;
    logic [1:0] sp, set;
    bit ok, wr, clr, irq_pre;
    pre = cnt_pre(r);
    sp = sts_post(r - 1);
    irq_pre = |(sts_post(r - 2) & m_ien);
    ok = a[1:0] == 2'b00 && a <= 32'h18;
    iv = !ok;
    case (a)
      32'h00:  v = 32'({m_ien, 7'b0, m_en});
      32'h04:  v = 32'({irq_pre, m_en});
      32'h08:  v = 32'(m_scr);
      32'h0C:  v = 32'(pre);
      32'h10:  v = 32'(m_cmp);
      32'h14:  v = 32'(sp);
      32'h18:  v = ver;
      default: v = 0;
    endcase
    wr = w && ok;
    clr = wr && a == 0 && d[1];
    set = m_en && !clr ? {pre == M - 1, (pre + 1) % M == m_cmp} : 2'b00;
    m_sts = (sp & ~(wr && a == 32'h14 ? d[1:0] : 2'b00)) | set;
    m_cbase = clr ? 0 : m_en ? (pre + 1) % M : pre;
    m_cw = r;
    if (wr && a == 0) begin m_en = d[0]; m_ien = d[9:8]; end
    if (wr && a == 32'h08) m_scr = longint'(d) % M;
    if (wr && a == 32'h10) m_cmp = longint'(d) % M;
  endtask

  task automatic check_irq();
    chk("irq_level", 32'(irq), 32'(|(sts_post(cyc - 1) & m_ien)));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); check_irq(); end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    x.w = w;
    x.e = cyc + 2 + D;
    model(w, a, d, x.e, x.d, x.inv);
    q.push_back(x);
    addr = a; wdat = d; rdy = w; req = !w;
  endtask

  task automatic finish(input int hold);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!(ack || rstb) && t < 64);
    if (!(ack || rstb)) chk("strobe_timeout", 32'(ack || rstb), 1);
    repeat (hold) @(negedge clk);
    rdy = 0; req = 0;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold);
    @(negedge clk);
    issue(w, a, d);
    finish(hold);
    idle(1);
  endtask

  task automatic rand_xact();
    int k;
    logic [31:0] a, d;
    k = $urandom_range(0, 10);
    a = k < 7 ? 32'(k * 4) :
        k == 7 ? 32'h1C + 32'($urandom_range(0, 3)) * 4 :
        k == 8 ? 32'h0100_0000 | 32'($urandom_range(0, 6)) * 4 :
        32'($urandom_range(0, 6)) * 4 + 32'($urandom_range(1, 3));
    d = $urandom;
    if (a == 32'h10 && d[0]) d = 32'(cnt_pre(cyc) + longint'($urandom_range(3, 30)));
    xact($urandom_range(0, 1) == 1, a, d, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_rdy"}, 32'(rstb), 0);
    chk({tag, "_inv"}, 32'(inv), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_data"}, rdat, 0);
  endtask

  task automatic run(input bit s);
    sel = s;
    D = s ? 3 : 0;
    M = s ? 64'd65536 : 64'd4294967296;
    ver = s ? 32'h0000_5A3C : 32'h0001_0000;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    chk_quiet("reset");
    xact(1, 32'h08, 32'hDEADBEEF, 0);
    xact(0, 32'h08, 0, 0);
    xact(0, 32'h1C, 0, 0);
    xact(0, 32'h09, 0, 0);
    xact(1, 32'h20, 32'h1234_5678, 0);
    for (int i = 0; i < 28; i += 4) xact(0, 32'(i), 0, 0);
    xact(0, 32'h18, 0, 10);
    for (int i = 0; i < 150; i++) rand_xact();
    xact(1, 32'h00, 32'h002, 0);
    xact(1, 32'h10, 32'd5, 0);
    xact(1, 32'h00, 32'h101, 0);
    idle(12);
    xact(0, 32'h14, 0, 0);
    xact(0, 32'h04, 0, 0);
    xact(0, 32'h0C, 0, 0);
    xact(1, 32'h14, 32'h1, 0);
    idle(3);
    xact(0, 32'h14, 0, 0);
    if (s) begin
      xact(1, 32'h00, 32'h002, 0);
      xact(1, 32'h00, 32'h201, 0);
      repeat (65540) @(negedge clk);
      check_irq();
      xact(0, 32'h14, 0, 0);
      xact(0, 32'h04, 0, 0);
      xact(1, 32'h00, 32'h003, 0);
      xact(0, 32'h0C, 0, 0);
      // reset lands while the read sits in its delay countdown
      @(negedge clk);
      addr = 32'h08; rdy = 0; req = 1;
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (3) begin @(negedge clk); chk_quiet("midreset"); end
      rst = 0;
      model_reset();
      issue(0, 32'h08, 0);
      finish(0);
      idle(1);
    end
    chk("queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (ack || rstb) begin
        if (q.size() == 0) chk("spurious_strobe", {30'b0, ack, rstb}, 0);
        else begin
          x = q.pop_front();
          chk("strobe_kind", {30'b0, ack, rstb}, x.w ? 32'd2 : 32'd1);
          chk("invalid_flag", 32'(inv), 32'(x.inv));
          chk("strobe_cycle", 32'(cyc), 32'(x.e));
          if (!x.w) chk("read_data", rdat, x.d);
        end
      end
    end
  end

  initial begin
    run(0);
    run(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
